// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ps2_pkg                                                     |
// | Brief   : Shared types, scan-code constants and frame FSM encoding    |
// |           for the PS/2 keyboard receiver.                             |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

  // One decoded key event as presented at the FIFO head
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // Prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard status / protocol bytes that never produce an event
  localparam logic [7:0] PS2_IGN_ERR0  = 8'h00;
  localparam logic [7:0] PS2_IGN_BAT   = 8'hAA;
  localparam logic [7:0] PS2_IGN_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_IGN_ACK   = 8'hFA;
  localparam logic [7:0] PS2_IGN_BATF  = 8'hFC;
  localparam logic [7:0] PS2_IGN_RESND = 8'hFE;
  localparam logic [7:0] PS2_IGN_ERR1  = 8'hFF;

  // Frame FSM encoding
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_data   = 2'd1;
  localparam logic [1:0] c_st_parity = 2'd2;
  localparam logic [1:0] c_st_stop   = 2'd3;

  function automatic logic is_ignored_code(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    case (code)
      PS2_IGN_ERR0, PS2_IGN_BAT, PS2_IGN_ECHO, PS2_IGN_ACK,
      PS2_IGN_BATF, PS2_IGN_RESND, PS2_IGN_ERR1: hit = 1'b1;
      default:                                   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : ps2_key_rx_if                                             |
// | Brief     : Key-event FIFO valid/ready port with occupancy count.     |
// | Rev       : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface ps2_key_rx_if #(
  parameter int CNT_W = 4
) ();
  logic             ev_valid;
  logic             ev_ready;
  logic [9:0]       ev_data;
  logic [CNT_W-1:0] ev_count;

  // Producer side (the receiver)
  modport master (output ev_valid, output ev_data, output ev_count, input ev_ready);
  // Consumer side (controller mapping logic)
  modport slave  (input ev_valid, input ev_data, input ev_count, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_line_filter                                              |
// | Brief  : Two-flop synchroniser followed by a glitch filter; output    |
// |          only follows the input after FILTER_LEN equal samples.       |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic line_i,
  output logic line_o
);
  localparam int CW = $clog2(FILTER_LEN);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q,  filt_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Count consecutive samples that disagree with the filtered level; flip once enough agree
  always_comb begin
    sync1_d = line_i;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Idle PS/2 lines are high, so everything resets to 1
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_key_rx                                                   |
// | Brief  : PS/2 keyboard receiver: filtered inputs, 11-bit frame check, |
// |          E0/F0 prefix decoding, typematic filter and event FIFO.      |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT_CYC   = 50000,
  parameter int REPEAT_FILTER = 1
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic         psClk,
  input  logic         psData,
  ps2_key_rx_if.master ev_if,
  output logic         frame_err,
  output logic         overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  // ---------------- input conditioning ----------------
  logic ps_clk_f;
  logic ps_data_f;
  logic ps_clk_prev_q, ps_clk_prev_d;
  logic fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .Clk(Clk), .reset_n(reset_n), .line_i(psClk), .line_o(ps_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .Clk(Clk), .reset_n(reset_n), .line_i(psData), .line_o(ps_data_f)
  );

  assign fall = ps_clk_prev_q & ~ps_clk_f;

  // ---------------- frame FSM ----------------
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout;
  logic          byte_done;
  logic          frm_err;

  // Stalled mid-frame: the host never gets another clock edge within the window
  assign timeout = (state_q != c_st_idle) && !fall && (tcnt_q == TW'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state_q <= c_st_idle;
    else          state_q <= state_d;
  end

  // Next state: advances on filtered psClk falls, timeout forces IDLE
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = c_st_idle;
    end else if (fall) begin
      case (state_q)
        c_st_idle:   if (!ps_data_f) state_d = c_st_data;
        c_st_data:   if (bit_cnt_q == 3'd7) state_d = c_st_parity;
        c_st_parity: state_d = c_st_stop;
        c_st_stop:   state_d = c_st_idle;
        default:     state_d = c_st_idle;
      endcase
    end
  end

  // FSM outputs: completed byte or framing error, both single-cycle
  always_comb begin
    byte_done = 1'b0;
    frm_err   = 1'b0;
    if (timeout) begin
      frm_err = 1'b1;
    end else if (fall) begin
      case (state_q)
        c_st_idle: frm_err = ps_data_f;
        c_st_stop: begin
          if (ps_data_f && (^{shift_q, parity_q})) byte_done = 1'b1;
          else                                     frm_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame datapath: shift register (LSB first), bit counter, parity and timeout counter
  always_comb begin
    ps_clk_prev_d = ps_clk_f;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    tcnt_d        = (state_q == c_st_idle || fall) ? '0 : tcnt_q + TW'(1);
    if (fall) begin
      case (state_q)
        c_st_idle: bit_cnt_d = '0;
        c_st_data: begin
          shift_d   = {ps_data_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        c_st_parity: parity_d = ps_data_f;
        default: ;
      endcase
    end
  end

  // ---------------- decoder ----------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [8:0] last_make_q, last_make_d;
  logic       dec_valid_q, dec_valid_d;
  key_event_t dec_ev_q, dec_ev_d;

  // Prefix tracking, ignored codes and typematic-repeat suppression
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    last_make_d = last_make_q;
    dec_valid_d = 1'b0;
    dec_ev_d    = dec_ev_q;
    if (frm_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done) begin
      if (shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!is_ignored_code(shift_q)) begin
          dec_ev_d    = {ext_q, brk_q, shift_q};
          dec_valid_d = 1'b1;
          if (REPEAT_FILTER != 0) begin
            if (!brk_q) begin
              // A make identical to the held key is an auto-repeat
              if ({ext_q, shift_q} == last_make_q) dec_valid_d = 1'b0;
              else                                 last_make_d = {ext_q, shift_q};
            end else if ({ext_q, shift_q} == last_make_q) begin
              last_make_d = '0;
            end
          end
        end
      end
    end
  end

  // ---------------- event FIFO ----------------
  key_event_t    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          ev_valid;
  logic          pop;
  logic          full;
  logic          wr_en;

  assign ev_valid = (count_q != '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = ev_valid & ev_if.ev_ready;

  // A push into a full FIFO still fits when the head leaves the same cycle
  always_comb begin
    wr_en       = dec_valid_q && (!full || pop);
    overflow_d  = dec_valid_q && full && !pop;
    frame_err_d = frm_err;
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset discards any partial frame, prefixes and queued events
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_clk_prev_q <= 1'b1;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tcnt_q        <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      last_make_q   <= '0;
      dec_valid_q   <= 1'b0;
      dec_ev_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      ps_clk_prev_q <= ps_clk_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tcnt_q        <= tcnt_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      last_make_q   <= last_make_d;
      dec_valid_q   <= dec_valid_d;
      dec_ev_q      <= dec_ev_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= dec_ev_q;
  end

  assign ev_if.ev_valid = ev_valid;
  assign ev_if.ev_data  = ev_valid ? mem_q[rd_ptr_q] : '0;
  assign ev_if.ev_count = count_q;
  assign frame_err      = frame_err_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ps2_key_rx                                                |
// | Brief  : Directed PS/2 frames with a queue-based event scoreboard.    |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_ps2_key_rx;
  localparam int FILTER_LEN  = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 1000;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF        = 20;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic ps_clk  = 1'b1;
  logic ps_data = 1'b1;
  logic frame_err;
  logic overflow;

  ps2_key_rx_if #(.CNT_W(CNT_W)) ev_if ();

  ps2_key_rx #(
    .FILTER_LEN   (FILTER_LEN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .REPEAT_FILTER(1)
  ) dut (
    .Clk      (clk),
    .reset_n  (rst_n),
    .psClk    (ps_clk),
    .psData   (ps_data),
    .ev_if    (ev_if),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         ferr_seen = 0;
  int         ovf_seen  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every accepted event is compared against the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) ferr_seen++;
      if (overflow)  ovf_seen++;
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got 0x%03h, expected none", ev_if.ev_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("event", {22'd0, ev_if.ev_data}, {22'd0, mon_exp});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    ps_data = b;
    tick(HALF);
    ps_clk = 1'b0;
    tick(HALF);
    ps_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    tick(HALF);
  endtask

  logic [7:0] fill_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] tmo_byte;
  int         lat;
  int         budget;

  initial begin
    ev_if.ev_ready = 1'b1;
    tick(5);
    // reset state
    check("rst_ev_valid",  {31'd0, ev_if.ev_valid}, 32'd0);
    check("rst_ev_count",  {28'd0, ev_if.ev_count}, 32'd0);
    check("rst_ev_data",   {22'd0, ev_if.ev_data},  32'd0);
    check("rst_frame_err", {31'd0, frame_err},      32'd0);
    check("rst_overflow",  {31'd0, overflow},       32'd0);
    rst_n = 1'b1;
    tick(30);

    // 1: 0x1C with latency measured from the raw stop-bit clock fall
    //    (2 sync + 8 filter samples -> stop sampled 10 edges in, +2 to ev_valid)
    exp_q.push_back(10'h01C);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(tmo_byte_init(i));
    send_bit(~^8'h1C);
    ps_data = 1'b1;
    tick(HALF);
    ps_clk = 1'b0;
    lat = 0;
    for (int i = 1; i <= 2 * HALF; i++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && ev_if.ev_valid) lat = i;
    end
    ps_clk = 1'b1;
    tick(HALF);
    check("latency", lat, FILTER_LEN + 4);
    // release the held key so later 1C makes are not repeats
    exp_q.push_back(10'h11C);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);

    // 2: extended break E0 F0 75
    exp_q.push_back(10'h375);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);

    // 3: parity error then good frame
    send_byte(8'h1C, 1'b1);
    tick(10);
    check("ferr_parity", ferr_seen, 1);
    exp_q.push_back(10'h01C);
    send_byte(8'h1C, 1'b0);

    // 4: stall after 4 data bits -> timeout, then a clean frame
    tmo_byte = 8'h32;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(tmo_byte[i]);
    ps_data = 1'b1;
    tick(TIMEOUT_CYC + 100);
    check("ferr_timeout", ferr_seen, 2);
    exp_q.push_back(10'h032);
    send_byte(8'h32, 1'b0);

    // 5: typematic filter 1C,1C,1C,F0,1C,1C -> 01C,11C,01C
    exp_q.push_back(10'h01C);
    exp_q.push_back(10'h11C);
    exp_q.push_back(10'h01C);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    tick(20);
    check("sb_drained_5", exp_q.size(), 0);

    // 6: fill FIFO with ready low, one extra make overflows
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back({2'b00, fill_codes[i]});
      send_byte(fill_codes[i], 1'b0);
    end
    tick(20);
    check("full_count",   {28'd0, ev_if.ev_count}, FIFO_DEPTH);
    check("full_valid",   {31'd0, ev_if.ev_valid}, 32'd1);
    check("full_head",    {22'd0, ev_if.ev_data},  32'h015);
    check("overflow_cnt", ovf_seen, 1);

    // reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    ps_data = 1'b0;
    tick(HALF);
    ps_clk = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, ev_if.ev_valid}, 32'd0);
    check("mid_rst_count", {28'd0, ev_if.ev_count}, 32'd0);
    check("mid_rst_data",  {22'd0, ev_if.ev_data},  32'd0);
    check("mid_rst_ferr",  {31'd0, frame_err},      32'd0);
    check("mid_rst_ovf",   {31'd0, overflow},       32'd0);
    exp_q.delete();
    ps_clk  = 1'b1;
    ps_data = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(30);
    check("post_rst_count", {28'd0, ev_if.ev_count}, 32'd0);

    // recovery after reset
    ev_if.ev_ready = 1'b1;
    exp_q.push_back(10'h01C);
    send_byte(8'h1C, 1'b0);

    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      tick(1);
      budget++;
    end
    check("sb_drained_end", exp_q.size(), 0);
    check("ferr_total", ferr_seen, 2);
    check("ovf_total", ovf_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic tmo_byte_init(input int i);
    logic [7:0] v;
    v = 8'h1C;
    return v[i];
  endfunction

endmodule
`default_nettype wire
